// File: rtl/div3_pkg.sv
// Shared types and helpers for the divisible-by-3 serial path:
// the word feeder FSM states, the detector remainder encoding and
// the bit-counter sizing rule used by the feeder.
package div3_pkg;

    // Word feeder control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } feeder_state_t;

    // Running remainder of the serial detector (value seen so far mod 3).
    typedef enum logic [1:0] {
        REM0 = 2'd0,
        REM1 = 2'd1,
        REM2 = 2'd2
    } rem_state_t;

    // Counter wide enough to hold every value 0..w without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div3_word_feeder_lead_one_det.sv
// WIDTH-bit priority encoder: reports the index of the most significant
// set bit and flags an all-zero input. Only used when the feeder is built
// with FEEDER_SKIP_LZ_EN, where it strips leading zeros off each word.
module lead_one_det #(
    parameter int WIDTH = 8,
    parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [IW-1:0]    idx_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        idx_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                idx_o  = IW'(i);
                zero_o = 1'b0;
            end else begin
                idx_o  = idx_o;
                zero_o = zero_o;
            end
        end
    end

endmodule

// File: rtl/div3_word_feeder.sv
// Parallel-to-serial feeder for the divisible-by-3 detector.
// Each accepted word produces a one-cycle clr_o (restarting the detector
// remainder) followed by the word MSB first on x_o, with last_o marking
// the bit on which the detector's div_o is the word verdict.
// Optional build macro: FEEDER_SKIP_LZ_EN -- leading zero bits of each word
// are skipped (they do not change the remainder); an all-zero word then
// sends a single 0 bit.
// All outputs come from flops: the output registers hold the decode of the
// next state, so they track the state register one-for-one except in the
// cycle right after reset, where they are still held at zero.
module div3_word_feeder
    import div3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o,
    output logic             clr_o
);

    localparam int CW = cnt_width(WIDTH);

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic ready_q, ready_d;
    logic x_q,     x_d;
    logic xv_q,    xv_d;
    logic last_q,  last_d;
    logic clr_q,   clr_d;

    logic             accept_s;
    logic [WIDTH-1:0] load_data_s;
    logic [CW-1:0]    load_cnt_s;

    // The registered ready is what the source sees, so it also gates acceptance.
    assign accept_s = in_valid_i & ready_q;

`ifdef FEEDER_SKIP_LZ_EN
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0] lead_idx_s;
    logic          lead_zero_s;
    logic [IW-1:0] lead_sh_s;

    lead_one_det #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_lead_one_det (
        .data_i (in_data_i),
        .idx_o  (lead_idx_s),
        .zero_o (lead_zero_s)
    );

    // Left-align the leading one and send only the bits from it downward.
    always_comb begin
        lead_sh_s = IW'(WIDTH - 1) - lead_idx_s;
        if (lead_zero_s) begin
            load_data_s = '0;
            load_cnt_s  = CW'(1);
        end else begin
            load_data_s = in_data_i << lead_sh_s;
            load_cnt_s  = CW'(lead_idx_s) + CW'(1);
        end
    end
`else
    // Full-width words: already left-aligned, always WIDTH bits long.
    assign load_data_s = in_data_i;
    assign load_cnt_s  = CW'(WIDTH);
`endif

    // Next-state and datapath update for the IDLE/LOAD/SHIFT controller.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shreg_d = load_data_s;
                    cnt_d   = load_cnt_s;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (cnt_q == CW'(1)) begin
                    if (accept_s) begin
                        // Back-to-back word: skip IDLE and restart directly.
                        shreg_d = load_data_s;
                        cnt_d   = load_cnt_s;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        ready_d = 1'b0;
        clr_d   = 1'b0;
        xv_d    = 1'b0;
        x_d     = 1'b0;
        last_d  = 1'b0;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
            end
            LOAD: begin
                clr_d = 1'b1;
            end
            SHIFT: begin
                xv_d = 1'b1;
                x_d  = shreg_d[WIDTH-1];
                if (cnt_d == CW'(1)) begin
                    last_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    last_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            clr_q   <= 1'b0;
            xv_q    <= 1'b0;
            x_q     <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            clr_q   <= clr_d;
            xv_q    <= xv_d;
            x_q     <= x_d;
            last_q  <= last_d;
        end
    end

    assign in_ready_o = ready_q;
    assign clr_o      = clr_q;
    assign x_valid_o  = xv_q;
    assign x_o        = x_q;
    assign last_o     = last_q;

endmodule

// File: tb/tb_div3_word_feeder.sv
// Directed bench for div3_word_feeder (WIDTH=8). Follows FEEDER_SKIP_LZ_EN
// for the expected serial length. A small mod-3 model stands in for the
// downstream detector and yields the per-word verdict on last_o.
module tb_div3_word_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         x_o;
    logic         x_valid_o;
    logic         last_o;
    logic         clr_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] w;
        int         n_off;
        int         n_on;
        bit         div;
    } vec_t;

    vec_t vecs [6] = '{
        '{8'h09, 8, 4, 1'b1},
        '{8'h0A, 8, 4, 1'b0},
        '{8'h00, 8, 1, 1'b1},
        '{8'hFF, 8, 8, 1'b1},
        '{8'h80, 8, 8, 1'b0},
        '{8'h01, 8, 1, 1'b0}
    };

    always #5 clk = ~clk;

    div3_word_feeder #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .x_o        (x_o),
        .x_valid_o  (x_valid_o),
        .last_o     (last_o),
        .clr_o      (clr_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_n(input int n_off, input int n_on);
`ifdef FEEDER_SKIP_LZ_EN
        return n_on;
`else
        return n_off;
`endif
    endfunction

    // Wait (bounded) for the negedge of the accepting cycle T.
    task automatic wait_accept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready_o && in_valid_i) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_accept"}, {31'd0, ok}, 32'd1);
    endtask

    // Check T+1 (clr) through T+1+N (last bit) and the detector verdict.
    task automatic stream(input logic [7:0] w, input int n, input bit exp_div, input string tag);
        int  rem;
        logic eb;
        logic lb;
        rem = 0;
        @(negedge clk);
        check_eq({tag, "_clr"}, {29'd0, clr_o, x_valid_o, in_ready_o}, 32'b100);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            eb = w[n - 1 - k];
            lb = (k == n - 1);
            check_eq({tag, "_bit"}, {27'd0, x_valid_o, x_o, last_o, in_ready_o, clr_o},
                     {27'd0, 1'b1, eb, lb, lb, 1'b0});
            rem = (rem * 2 + int'(x_o)) % 3;
        end
        check_eq({tag, "_div"}, {31'd0, rem == 0}, {31'd0, exp_div});
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check_eq({tag, "_idle"}, {28'd0, x_valid_o, last_o, clr_o, in_ready_o}, 32'b0001);
    endtask

    task automatic run_word(input logic [7:0] w, input int n, input bit exp_div, input string tag);
        in_valid_i = 1'b1;
        in_data_i  = w;
        wait_accept(tag);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        stream(w, n, exp_div, tag);
        check_idle(tag);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outs", {27'd0, in_ready_o, x_o, x_valid_o, last_o, clr_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_fall0", {27'd0, in_ready_o, x_o, x_valid_o, last_o, clr_o}, 32'd0);
        @(negedge clk);
        check_eq("rst_fall1", {27'd0, in_ready_o, x_o, x_valid_o, last_o, clr_o}, 32'b10000);

        // Single words from the table.
        foreach (vecs[i]) begin
            run_word(vecs[i].w, pick_n(vecs[i].n_off, vecs[i].n_on), vecs[i].div,
                     $sformatf("w%02h", vecs[i].w));
        end

        // Back-to-back with in_valid_i held: 0x07 then 0x0C.
        @(posedge clk);
        #1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h07;
        wait_accept("b2b_a");
        @(posedge clk);
        #1;
        in_data_i = 8'h0C;
        stream(8'h07, pick_n(8, 3), 1'b0, "b2b_a");
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        stream(8'h0C, pick_n(8, 4), 1'b1, "b2b_b");
        check_idle("b2b");

        // Reset in the middle of word 0x5A, asserted during cycle T+4.
        @(posedge clk);
        #1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h5A;
        wait_accept("mid");
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        check_eq("mid_clr", {31'd0, clr_o}, 32'd1);
        @(negedge clk);
        check_eq("mid_bit0", {31'd0, x_valid_o}, 32'd1);
        @(negedge clk);
        check_eq("mid_bit1", {31'd0, x_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_t5", {27'd0, in_ready_o, x_o, x_valid_o, last_o, clr_o}, 32'd0);
        @(negedge clk);
        check_eq("mid_t6", {27'd0, in_ready_o, x_o, x_valid_o, last_o, clr_o}, 32'b10000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_quiet", {28'd0, x_o, x_valid_o, last_o, clr_o}, 32'd0);
        end
        run_word(8'h03, pick_n(8, 2), 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div3_word_feeder.md
# div3_word_feeder

- Converts parallel words into the MSB-first serial bit stream consumed by the divisible-by-3 detector.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Issues a one-cycle clear pulse ahead of each word so the detector's remainder restarts at zero.
- Emits the word bit by bit and flags the final bit, so the detector's combinational `div_o` on that cycle is the per-word verdict.
- Sits directly upstream of the detector: `clr_o` drives the detector reset, `x_o` drives `x_i`.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range ≥ 2.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid_i  input  1  word available
- in_ready_o  output  1  feeder can accept a word this cycle
- in_data_i  input  WIDTH  word, bit WIDTH-1 is MSB
- x_o  output  1  serial bit to detector; 0 when x_valid_o=0
- x_valid_o  output  1  x_o carries a word bit
- last_o  output  1  x_o is the final bit of the current word
- clr_o  output  1  one-cycle restart pulse for detector remainder

## Operation
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: in_ready_o=1. On accept, capture the word into the shift register (left-aligned), load the bit counter, go to LOAD.
  - LOAD: clr_o=1, in_ready_o=0, x_valid_o=0. Always go to SHIFT next cycle.
  - SHIFT: x_valid_o=1, x_o=shreg[WIDTH-1]. Shift left one bit and decrement the counter each cycle.
  - SHIFT, counter==1: last_o=1 and in_ready_o=1. On accept, go to LOAD with the new word; otherwise go to IDLE.
- Accept = in_valid_i & in_ready_o. in_valid_i while in_ready_o=0 is ignored; the source holds the word.
- Bit counter width: $clog2(WIDTH+1); it never wraps.
- Downstream verdict: detector `div_o` sampled when x_valid_o & last_o = 1 is the word's divisible-by-3 result.
- Reset (any state, including mid-SHIFT):
  - Next state IDLE; counter and shift register cleared.
  - All outputs 0, including in_ready_o while reset is high.
  - A partially sent word is dropped. No clr_o is issued; the detector shares reset.
- Outputs are decoded from registered state only; there are no input-to-output combinational paths except none.

## Timing
- Word accepted at cycle T: clr_o at T+1; bits at T+2 … T+1+N; last_o at T+1+N.
  - N = WIDTH without the macro.
  - With the macro, N is as defined under Configuration.
- Back-to-back: accept at T+1+N, next LOAD at T+2+N. Sustained throughput is one word per N+1 cycles.
- First accept after reset deassertion: the cycle after reset falls (IDLE, in_ready_o=1).

## Configuration
- FEEDER_SKIP_LZ_EN defined: leading zero bits are not sent (they do not change mod-3 remainder).
  - At accept, the word is shifted left so its MSB-most 1 sits at bit WIDTH-1.
  - N = index of that 1 + 1.
  - An all-zero word sends a single 0 bit (N=1) with last_o.
- FEEDER_SKIP_LZ_EN undefined: N = WIDTH always and the leading-one logic is absent.

## Structure
- Package div3_pkg:
  - feeder_state_t enum {IDLE, LOAD, SHIFT}.
  - Shared remainder-state typedef for the detector.
  - Counter-width function.
- Sub-module lead_one_det (WIDTH-bit priority encoder):
  - Outputs the MSB-most set index and an all-zero flag.
  - Instantiated only under FEEDER_SKIP_LZ_EN.

## Test plan
- WIDTH=8, macro off, word 8'h09 accepted at T:
  - clr_o at T+1.
  - x_o = 0,0,0,0,1,0,0,1 at T+2…T+9, last_o at T+9.
  - Detector div_o=1 at T+9.
- Macro on, word 8'h09 accepted at T: x_o = 1,0,0,1 at T+2…T+5, last_o at T+5.
- Macro on, word 8'h00: single bit 0 at T+2 with last_o; detector div_o=1.
- Macro on, word 8'h0A (decimal 10): x_o = 1,0,1,0 at T+2…T+5, last_o at T+5; detector div_o=0 at T+5.
- in_valid_i held high with words 8'h07 then 8'h0C, macro off:
  - Second word accepted at T+9; clr_o at T+10; last_o at T+18.
  - in_ready_o=0 at T+1…T+8.
  - div_o=0 for the first word, div_o=1 for the second.
- Reset asserted for one cycle at T+4 mid-word:
  - From T+5, all outputs 0 and no further bits.
  - in_ready_o=1 at T+6.
  - A new 8'h03 word completes with div_o=1.
